// File: rtl/instr_decode.sv
// instr_decode: RV32I decode stage feeding execute through a small output FIFO.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   fetched_valid/ready/instr/pc    incoming fetched word stream
//   decoded_valid/ready             outgoing decoded stream handshake
//   decoded_op/rd/funct3/imm        decoded fields of the FIFO head
//   decoded_rs1_val/rs2_val/pc      operand values and pc of the FIFO head
//   rs1_idx, rs2_idx                register file read indices
//   rs1_rdata, rs2_rdata            combinational register file read data
//   flush                           synchronous pipeline flush
// decoded_op encoding: 0 INVALID, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD,
//   7 STORE, 8 OP_IMM, 9 OP, 10 MISC_MEM, 11 SYSTEM.
module instr_decode #(
   parameter int BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetched_valid,
   output logic        fetched_ready,
   input  logic [31:0] fetched_instr,
   input  logic [31:0] fetched_pc,
   output logic        decoded_valid,
   input  logic        decoded_ready,
   output logic [3:0]  decoded_op,
   output logic [4:0]  decoded_rd,
   output logic [2:0]  decoded_funct3,
   output logic [31:0] decoded_imm,
   output logic [31:0] decoded_rs1_val,
   output logic [31:0] decoded_rs2_val,
   output logic [31:0] decoded_pc,
   output logic [4:0]  rs1_idx,
   output logic [4:0]  rs2_idx,
   input  logic [31:0] rs1_rdata,
   input  logic [31:0] rs2_rdata,
   input  logic        flush
);
   localparam int AW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam logic [AW-1:0] LAST = AW'(BUF_DEPTH - 1);
   localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
   localparam logic [3:0] OP_INVALID = 4'd0, OP_LUI = 4'd1, OP_AUIPC = 4'd2, OP_JAL = 4'd3,
      OP_JALR = 4'd4, OP_BRANCH = 4'd5, OP_LOAD = 4'd6, OP_STORE = 4'd7, OP_OP_IMM = 4'd8,
      OP_OP = 4'd9, OP_MISC_MEM = 4'd10, OP_SYSTEM = 4'd11;
   typedef struct packed {
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [31:0] imm;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] pc;
   } dec_t;
   dec_t          mem [BUF_DEPTH];
   dec_t          dec;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop;
   logic [31:0]   w;
   logic [4:0]    opc;
   logic [3:0]    op;
   logic [31:0]   imm, imm_i, imm_s, imm_b, imm_u, imm_j;
   assign w       = fetched_instr;
   assign opc     = w[6:2];
   assign rs1_idx = w[19:15];
   assign rs2_idx = w[24:20];
   assign imm_i = {{20{w[31]}}, w[31:20]};
   assign imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
   assign imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
   assign imm_u = {w[31:12], 12'b0};
   assign imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
   always_comb begin
      op = w[1:0] != 2'b11 ? OP_INVALID :
           opc == 5'b01101 ? OP_LUI      :
           opc == 5'b00101 ? OP_AUIPC    :
           opc == 5'b11011 ? OP_JAL      :
           opc == 5'b11001 ? OP_JALR     :
           opc == 5'b11000 ? OP_BRANCH   :
           opc == 5'b00000 ? OP_LOAD     :
           opc == 5'b01000 ? OP_STORE    :
           opc == 5'b00100 ? OP_OP_IMM   :
           opc == 5'b01100 ? OP_OP       :
           opc == 5'b00011 ? OP_MISC_MEM :
           opc == 5'b11100 ? OP_SYSTEM   : OP_INVALID;
      // R-type carries funct7 in imm[11:5] for the execute units
      imm = (op == OP_LUI || op == OP_AUIPC) ? imm_u :
            op == OP_JAL     ? imm_j :
            op == OP_BRANCH  ? imm_b :
            op == OP_STORE   ? imm_s :
            op == OP_OP      ? {20'b0, w[31:25], 5'b0} :
            op == OP_INVALID ? 32'h0 : imm_i;
   end
   assign dec = {op, w[11:7], w[14:12], imm,
                 rs1_idx == 5'd0 ? 32'h0 : rs1_rdata,
                 rs2_idx == 5'd0 ? 32'h0 : rs2_rdata,
                 fetched_pc};
   // ready depends only on registered count so execute stalls never reach fetch combinationally
   assign fetched_ready = !rst && count < FULL;
   assign decoded_valid = count != '0;
   assign push = fetched_valid && fetched_ready;
   assign pop  = decoded_valid && decoded_ready;
   assign {decoded_op, decoded_rd, decoded_funct3, decoded_imm,
           decoded_rs1_val, decoded_rs2_val, decoded_pc} = mem[rd_ptr];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= dec;
   end
endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: randomized and directed checks of instr_decode against a queue-based model.
module tb_instr_decode;
   logic        clk = 1'b0;
   logic        rst;
   logic        fetched_valid, fetched_ready;
   logic [31:0] fetched_instr, fetched_pc;
   logic        decoded_valid, decoded_ready;
   logic [3:0]  decoded_op;
   logic [4:0]  decoded_rd;
   logic [2:0]  decoded_funct3;
   logic [31:0] decoded_imm, decoded_rs1_val, decoded_rs2_val, decoded_pc;
   logic [4:0]  rs1_idx, rs2_idx;
   logic [31:0] rs1_rdata, rs2_rdata;
   logic        flush;
   logic [31:0] regs [32];
   int          checks = 0;
   int          errors = 0;
   bit          run = 1'b0;
   logic [31:0] pc_ctr = 32'h1000;

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [31:0] imm, rs1, rs2, pc;
   } exp_t;
   exp_t q[$];

   instr_decode #(.BUF_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .fetched_valid(fetched_valid), .fetched_ready(fetched_ready),
      .fetched_instr(fetched_instr), .fetched_pc(fetched_pc),
      .decoded_valid(decoded_valid), .decoded_ready(decoded_ready),
      .decoded_op(decoded_op), .decoded_rd(decoded_rd), .decoded_funct3(decoded_funct3),
      .decoded_imm(decoded_imm), .decoded_rs1_val(decoded_rs1_val),
      .decoded_rs2_val(decoded_rs2_val), .decoded_pc(decoded_pc),
      .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
      .flush(flush)
   );

   always #5 clk = ~clk;
   always_comb rs1_rdata = regs[rs1_idx];
   always_comb rs2_rdata = regs[rs2_idx];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
      end
   endtask

   function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
      exp_t e;
      logic [31:0] si;
      si = 32'($signed(w) >>> 20);
      e.rd = w[11:7];
      e.f3 = w[14:12];
      e.pc = pc;
      e.rs1 = (w[19:15] == 5'd0) ? 32'h0 : regs[w[19:15]];
      e.rs2 = (w[24:20] == 5'd0) ? 32'h0 : regs[w[24:20]];
      e.op = 4'd0;
      e.imm = 32'h0;
      case (w[6:0])
         7'h37: begin e.op = 4'd1; e.imm = w & 32'hFFFFF000; end
         7'h17: begin e.op = 4'd2; e.imm = w & 32'hFFFFF000; end
         7'h6F: begin e.op = 4'd3; e.imm = (w[31] ? 32'hFFF00000 : 32'h0) | (32'(w[19:12]) << 12)
                      | (32'(w[20]) << 11) | (32'(w[30:21]) << 1); end
         7'h67: begin e.op = 4'd4; e.imm = si; end
         7'h63: begin e.op = 4'd5; e.imm = (w[31] ? 32'hFFFFF000 : 32'h0) | (32'(w[7]) << 11)
                      | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1); end
         7'h03: begin e.op = 4'd6; e.imm = si; end
         7'h23: begin e.op = 4'd7; e.imm = (si & ~32'h1F) | 32'(w[11:7]); end
         7'h13: begin e.op = 4'd8; e.imm = si; end
         7'h33: begin e.op = 4'd9; e.imm = 32'(w[31:25]) * 32; end
         7'h0F: begin e.op = 4'd10; e.imm = si; end
         7'h73: begin e.op = 4'd11; e.imm = si; end
         default: ;
      endcase
      return e;
   endfunction

   // single compare process: every falling edge, outputs against the model queue
   always @(negedge clk) begin
      if (run) begin
         chk("ready", {31'b0, fetched_ready}, {31'b0, !rst && q.size() < 2});
         chk("valid", {31'b0, decoded_valid}, {31'b0, q.size() != 0});
         chk("rs1_idx", {27'b0, rs1_idx}, {27'b0, fetched_instr[19:15]});
         chk("rs2_idx", {27'b0, rs2_idx}, {27'b0, fetched_instr[24:20]});
         if (q.size() != 0) begin
            chk("op", {28'b0, decoded_op}, {28'b0, q[0].op});
            chk("rd", {27'b0, decoded_rd}, {27'b0, q[0].rd});
            chk("funct3", {29'b0, decoded_funct3}, {29'b0, q[0].f3});
            chk("imm", decoded_imm, q[0].imm);
            chk("rs1_val", decoded_rs1_val, q[0].rs1);
            chk("rs2_val", decoded_rs2_val, q[0].rs2);
            chk("pc", decoded_pc, q[0].pc);
         end
      end
   end

   // one cycle: drive inputs, advance the model at the rising edge, return just after the falling edge
   task automatic drive(input logic fv, input logic [31:0] w, input logic dr, input logic fl);
      exp_t e;
      bit   push, pop;
      fetched_valid = fv;
      fetched_instr = w;
      fetched_pc = pc_ctr;
      pc_ctr += 4;
      decoded_ready = dr;
      flush = fl;
      e = model(w, fetched_pc);
      push = fv && !rst && q.size() < 2;
      pop = dr && q.size() != 0;
      @(posedge clk);
      if (rst || fl) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(e);
      end
      @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] addi_rd(input int r);
      return 32'h00000013 | (32'(r) << 7);
   endfunction

   logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

   initial begin
      logic [31:0] w;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      regs[0] = 32'h0000DEAD;
      rst = 1'b1;
      fetched_valid = 1'b0;
      fetched_instr = 32'h0;
      fetched_pc = 32'h0;
      decoded_ready = 1'b0;
      flush = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", {31'b0, fetched_ready}, 32'h0);
      chk("rst_valid", {31'b0, decoded_valid}, 32'h0);
      rst = 1'b0;
      run = 1'b1;
      #1 chk("post_rst_ready", {31'b0, fetched_ready}, 32'h1);
      // addi x1,x2,-1
      regs[2] = 32'd5;
      drive(1, 32'hFFF10093, 0, 0);
      chk("t1_valid", {31'b0, decoded_valid}, 32'h1);
      chk("t1_op", {28'b0, decoded_op}, 32'd8);
      chk("t1_rd", {27'b0, decoded_rd}, 32'd1);
      chk("t1_f3", {29'b0, decoded_funct3}, 32'd0);
      chk("t1_imm", decoded_imm, 32'hFFFFFFFF);
      chk("t1_rs1", decoded_rs1_val, 32'd5);
      drive(0, 32'h0, 1, 0);
      // sub x3,x4,x5
      regs[4] = 32'd9;
      regs[5] = 32'd2;
      drive(1, 32'h405201B3, 0, 0);
      chk("t2_op", {28'b0, decoded_op}, 32'd9);
      chk("t2_rd", {27'b0, decoded_rd}, 32'd3);
      chk("t2_imm", decoded_imm, 32'h00000400);
      chk("t2_rs1", decoded_rs1_val, 32'd9);
      chk("t2_rs2", decoded_rs2_val, 32'd2);
      drive(0, 32'h0, 1, 0);
      // beq x0,x0,-4 with garbage on x0 read data
      drive(1, 32'hFE000EE3, 0, 0);
      chk("t3_op", {28'b0, decoded_op}, 32'd5);
      chk("t3_imm", decoded_imm, 32'hFFFFFFFC);
      chk("t3_rs1", decoded_rs1_val, 32'h0);
      chk("t3_rs2", decoded_rs2_val, 32'h0);
      drive(0, 32'h0, 1, 0);
      // back-pressure: two accepted, third waits for first pop
      drive(1, addi_rd(10), 0, 0);
      drive(1, addi_rd(11), 0, 0);
      chk("t4_full_ready", {31'b0, fetched_ready}, 32'h0);
      drive(1, addi_rd(12), 0, 0);
      chk("t4_hold_rd", {27'b0, decoded_rd}, 32'd10);
      drive(1, addi_rd(12), 1, 0);
      chk("t4_pop1_rd", {27'b0, decoded_rd}, 32'd11);
      chk("t4_ready_back", {31'b0, fetched_ready}, 32'h1);
      drive(1, addi_rd(12), 1, 0);
      chk("t4_pop2_rd", {27'b0, decoded_rd}, 32'd12);
      drive(0, 32'h0, 1, 0);
      chk("t4_empty", {31'b0, decoded_valid}, 32'h0);
      // flush with FIFO full, then flush with one entry and a live push
      drive(1, addi_rd(20), 0, 0);
      drive(1, addi_rd(21), 0, 0);
      drive(1, addi_rd(22), 0, 1);
      chk("t5_flush_full", {31'b0, decoded_valid}, 32'h0);
      drive(1, addi_rd(23), 0, 0);
      drive(1, addi_rd(24), 0, 1);
      chk("t5_flush_push", {31'b0, decoded_valid}, 32'h0);
      drive(1, addi_rd(25), 0, 0);
      chk("t5_next_rd", {27'b0, decoded_rd}, 32'd25);
      drive(0, 32'h0, 1, 0);
      // invalid opcode, then async reset mid-stream
      drive(1, 32'h0000007F, 0, 0);
      chk("t6_invalid", {28'b0, decoded_op}, 32'd0);
      drive(1, addi_rd(30), 0, 0);
      rst = 1'b1;
      q.delete();
      #1;
      chk("t6_rst_valid", {31'b0, decoded_valid}, 32'h0);
      chk("t6_rst_ready", {31'b0, fetched_ready}, 32'h0);
      drive(1, addi_rd(31), 1, 0);
      rst = 1'b0;
      #1 chk("t6_release_ready", {31'b0, fetched_ready}, 32'h1);
      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         w = $urandom;
         if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 10)];
         if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 31)] = $urandom;
         drive($urandom_range(0, 9) < 7, w, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
